// File: rtl/timer_cmd_sequencer_if.sv
// Command and timer-register channels of the PWM job sequencer.
// The slave modport is the sequencer. The master modport is the host/timer side.
interface timer_cmd_sequencer_if;
    logic        iCmd_Valid;
    logic        oCmd_Ready;
    logic [15:0] iPeriod;
    logic [15:0] iDuty;
    logic [15:0] iRepeat;
    logic [1:0]  oAddr;
    logic        oWe;
    logic [15:0] oWdata;
    logic        oStart;
    logic        iTimer_End;

    modport slave (
        input  iCmd_Valid, iPeriod, iDuty, iRepeat, iTimer_End,
        output oCmd_Ready, oAddr, oWe, oWdata, oStart
    );

    modport master (
        output iCmd_Valid, iPeriod, iDuty, iRepeat, iTimer_End,
        input  oCmd_Ready, oAddr, oWe, oWdata, oStart
    );
endinterface

// File: rtl/timer_cmd_sequencer.sv
// Queues PWM jobs {period, duty, repeat} and runs them on the PWM timer one at a time.
// Each job programs max/pwm/stop, pulses start, then waits for the timer end window to close.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a queued job; pops and latches it
// WR_MAX   | writing period to timer register 0
// WR_PWM   | writing min(duty, period) to timer register 1
// WR_STOP  | writing repeat to timer register 2
// START    | one-cycle start pulse to the timer
// WAIT_HI  | waiting for the timer end window to open
// WAIT_LO  | waiting for the timer end window to close
module timer_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    timer_cmd_sequencer_if.slave  bus,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oErr,
    output logic [15:0]           oDone_Cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_MAX,
        S_WR_PWM,
        S_WR_STOP,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [47:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [47:0]   head;

    state_t        state;
    logic [15:0]   job_period;
    logic [15:0]   job_duty;
    logic [15:0]   job_repeat;
    logic [15:0]   duty_clamped;
    logic          done_q;
    logic          err_q;
    logic [15:0]   done_cnt_q;

    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = bus.iCmd_Valid && !fifo_full;
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.iPeriod, bus.iDuty, bus.iRepeat};
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= S_IDLE;
            job_period <= '0;
            job_duty   <= '0;
            job_repeat <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {job_period, job_duty, job_repeat} <= head;
                        // A zero period would never end; reject the job without touching the timer
                        if (head[47:32] == 16'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            state <= S_WR_MAX;
                        end
                    end
                end
                S_WR_MAX:  state <= S_WR_PWM;
                S_WR_PWM:  state <= S_WR_STOP;
                S_WR_STOP: state <= S_START;
                S_START:   state <= S_WAIT_HI;
                S_WAIT_HI: begin
                    if (bus.iTimer_End) begin
                        state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.iTimer_End) begin
                        done_q     <= 1'b1;
                        done_cnt_q <= done_cnt_q + 16'd1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign duty_clamped = (job_duty > job_period) ? job_period : job_duty;

    always_comb begin
        bus.oWe    = 1'b0;
        bus.oAddr  = 2'd0;
        bus.oWdata = 16'd0;
        bus.oStart = 1'b0;
        case (state)
            S_WR_MAX: begin
                bus.oWe    = 1'b1;
                bus.oAddr  = 2'd0;
                bus.oWdata = job_period;
            end
            S_WR_PWM: begin
                bus.oWe    = 1'b1;
                bus.oAddr  = 2'd1;
                bus.oWdata = duty_clamped;
            end
            S_WR_STOP: begin
                bus.oWe    = 1'b1;
                bus.oAddr  = 2'd2;
                bus.oWdata = job_repeat;
            end
            S_START: bus.oStart = 1'b1;
            default: ;
        endcase
    end

    assign bus.oCmd_Ready = !fifo_full;
    assign oBusy          = (state != S_IDLE);
    assign oDone          = done_q;
    assign oErr           = err_q;
    assign oDone_Cnt      = done_cnt_q;

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Scoreboard bench for timer_cmd_sequencer with a behavioural PWM timer model.
// Expected bus events are queued per accepted job and popped by an independent monitor.
module tb_timer_cmd_sequencer;

    localparam int K_WR    = 0;
    localparam int K_START = 1;
    localparam int K_ERR   = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        oBusy;
    logic        oDone;
    logic        oErr;
    logic [15:0] oDone_Cnt;

    timer_cmd_sequencer_if bus();

    timer_cmd_sequencer #(.DEPTH(4), .AW(2)) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .bus       (bus),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oErr      (oErr),
        .oDone_Cnt (oDone_Cnt)
    );

    always #5 iCLK = ~iCLK;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  model_cnt = 0;
    int  n_wr = 0, n_start = 0, n_err_ev = 0, n_done = 0;
    int  last_wr_cyc [4];
    int  last_wr_data [4];
    int  last_start_cyc = -1, last_err_cyc = -1, last_done_cyc = -1;

    logic te_model = 1'b0;
    logic te_force = 1'b0;
    logic hold = 1'b0;
    int   tm_st = 0, tm_dly = 0, tm_hi = 0, fall_cyc = -1;

    assign bus.iTimer_End = te_model | te_force;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: each accepted job yields a fixed sequence of bus events, in FIFO order
    task automatic model_push(input int p, input int d, input int r);
        if (p == 0) begin
            exp_q.push_back('{K_ERR, 0, 0});
        end else begin
            model_cnt = (model_cnt + 1) % 65536;
            exp_q.push_back('{K_WR, 0, p});
            exp_q.push_back('{K_WR, 1, (d < p) ? d : p});
            exp_q.push_back('{K_WR, 2, r});
            exp_q.push_back('{K_START, 0, 0});
            exp_q.push_back('{K_DONE, 0, model_cnt});
        end
    endtask

    task automatic sb_pop(input int kind, input int a, input int d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got event kind %0d addr %0d data %0d, expected no event (cycle %0d)",
                     kind, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", kind, e.kind);
            check("sb_addr", a, e.addr);
            check("sb_data", d, e.data);
        end
    endtask

    always @(negedge iCLK) begin
        if (!iRST) begin
            if (bus.oWe) begin
                last_wr_cyc[bus.oAddr]  = cyc;
                last_wr_data[bus.oAddr] = int'(bus.oWdata);
                n_wr++;
                sb_pop(K_WR, int'(bus.oAddr), int'(bus.oWdata));
            end else begin
                check("bus_idle_zero", int'({bus.oAddr, bus.oWdata}), 0);
            end
            if (bus.oStart) begin
                last_start_cyc = cyc;
                n_start++;
                sb_pop(K_START, 0, 0);
            end
            if (oErr) begin
                last_err_cyc = cyc;
                n_err_ev++;
                sb_pop(K_ERR, 0, 0);
            end
            if (oDone) begin
                last_done_cyc = cyc;
                n_done++;
                sb_pop(K_DONE, 0, int'(oDone_Cnt));
            end
        end
    end

    // Timer model: after start, a short random delay, then the end window is high for 11 cycles
    always @(negedge iCLK) begin
        if (iRST) begin
            tm_st    = 0;
            te_model = 1'b0;
        end else if (bus.oStart) begin
            tm_st    = 1;
            tm_dly   = $urandom_range(1, 4);
            te_model = 1'b0;
        end else begin
            case (tm_st)
                1: begin
                    if (tm_dly > 0) tm_dly--;
                    else if (!hold) begin
                        te_model = 1'b1;
                        tm_hi    = 11;
                        tm_st    = 2;
                    end
                end
                2: begin
                    tm_hi--;
                    if (tm_hi == 0) begin
                        te_model = 1'b0;
                        fall_cyc = cyc;
                        tm_st    = 0;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic push(input int p, input int d, input int r, output int waited, output int acc_cyc);
        logic rdy;
        waited = 0;
        acc_cyc = -1;
        bus.iCmd_Valid = 1'b1;
        bus.iPeriod    = 16'(p);
        bus.iDuty      = 16'(d);
        bus.iRepeat    = 16'(r);
        forever begin
            rdy = bus.oCmd_Ready;
            @(negedge iCLK);
            if (rdy) break;
            waited++;
            if (waited > 500) break;
        end
        bus.iCmd_Valid = 1'b0;
        if (waited > 500) begin
            check("push_timeout", 1, 0);
        end else begin
            model_push(p, d, r);
            acc_cyc = cyc;
        end
    endtask

    task automatic do_reset(input int n);
        iRST = 1'b1;
        bus.iCmd_Valid = 1'b0;
        hold = 1'b0;
        te_force = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        repeat (n) @(negedge iCLK);
        iRST = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || oBusy) && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        check("drain_left_events", exp_q.size(), 0);
        check("drain_busy", int'(oBusy), 0);
    endtask

    task automatic wait_start(input int target, input int budget);
        int k = 0;
        while (n_start < target && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        check("wait_start_reached", int'(n_start >= target), 1);
    endtask

    initial begin
        int w, c0, ws[5], acc, wr_before, cnt_before, ev_before;
        bus.iCmd_Valid = 1'b0;
        bus.iPeriod    = 16'd0;
        bus.iDuty      = 16'd0;
        bus.iRepeat    = 16'd0;

        // reset state
        do_reset(2);
        check("rst_we", int'(bus.oWe), 0);
        check("rst_start", int'(bus.oStart), 0);
        check("rst_addr_wdata", int'({bus.oAddr, bus.oWdata}), 0);
        check("rst_busy", int'(oBusy), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_err", int'(oErr), 0);
        check("rst_ready", int'(bus.oCmd_Ready), 1);
        check("rst_cnt", int'(oDone_Cnt), 0);

        // single job, cycle-exact program sequence
        push(4, 2, 1, w, c0);
        wait_drain(200);
        check("t2_wr0_cyc", last_wr_cyc[0], c0 + 1);
        check("t2_wr1_cyc", last_wr_cyc[1], c0 + 2);
        check("t2_wr2_cyc", last_wr_cyc[2], c0 + 3);
        check("t2_start_cyc", last_start_cyc, c0 + 4);
        check("t2_done_after_fall", last_done_cyc, fall_cyc + 1);
        check("t2_cnt", int'(oDone_Cnt), 1);

        // FIFO full while a job sits in WAIT_HI
        hold = 1'b1;
        push(7, 3, 2, w, c0);
        wait_start(n_start + 1, 50);
        @(negedge iCLK);
        check("t3_busy_wait_hi", int'(oBusy), 1);
        for (int i = 0; i < 4; i++) begin
            push(10 + i, i, i, ws[i], acc);
            check("t3_accept_no_stall", ws[i], 0);
        end
        check("t3_ready_full", int'(bus.oCmd_Ready), 0);
        fork
            push(20, 25, 3, ws[4], acc);
            begin
                repeat (5) @(negedge iCLK);
                hold = 1'b0;
            end
        join
        check("t3_fifth_stalled", int'(ws[4] >= 5), 1);
        wait_drain(600);

        // zero period is rejected, next job runs normally
        wr_before  = n_wr;
        cnt_before = int'(oDone_Cnt);
        push(0, 3, 3, w, c0);
        repeat (4) @(negedge iCLK);
        check("t4_err_cyc", last_err_cyc, c0 + 1);
        check("t4_no_write", n_wr, wr_before);
        check("t4_cnt_same", int'(oDone_Cnt), cnt_before);
        push(5, 1, 0, w, c0);
        wait_drain(200);
        check("t4_cnt_next", int'(oDone_Cnt), (cnt_before + 1) % 65536);

        // duty clamped to period
        push(5, 9, 2, w, c0);
        wait_drain(200);
        check("t5_clamp", last_wr_data[1], 5);

        // end window high in IDLE does not block the pop
        te_force = 1'b1;
        push(3, 1, 0, w, c0);
        @(negedge iCLK);
        check("te_idle_pop_we", int'(bus.oWe), 1);
        te_force = 1'b0;
        wait_drain(200);

        // randomized jobs with random spacing
        for (int i = 0; i < 40; i++) begin
            int p, d, r, sel;
            sel = $urandom_range(0, 9);
            p = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(1, 40));
            d = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 50));
            r = int'($urandom_range(0, 65535));
            push(p, d, r, w, c0);
            repeat ($urandom_range(0, 3)) @(negedge iCLK);
        end
        wait_drain(3000);

        // reset during WAIT_HI with two jobs queued
        hold = 1'b1;
        push(6, 2, 1, w, c0);
        wait_start(n_start + 1, 50);
        @(negedge iCLK);
        push(8, 1, 1, w, c0);
        push(9, 1, 1, w, c0);
        ev_before = n_wr + n_start + n_done + n_err_ev;
        do_reset(1);
        check("t6_busy", int'(oBusy), 0);
        check("t6_cnt", int'(oDone_Cnt), 0);
        check("t6_ready", int'(bus.oCmd_Ready), 1);
        check("t6_done", int'(oDone), 0);
        repeat (12) @(negedge iCLK);
        check("t6_no_events", n_wr + n_start + n_done + n_err_ev, ev_before);
        check("t6_still_idle", int'(oBusy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
